one_max_solver: RTL and testbench
=================================

// Module: one_max_solver
// PURPOSE
//   Hardware local-search solver for the OneMax problem: maximise the number of 1s in an
//   N_BITS-wide vector. After a start pulse it builds a pseudo-random initial vector, then
//   hill-climbs by random single-bit flips until the optimum or an iteration cap is reached.
//   Self-contained accelerator core; the host sees only start/done and the result.
// PARAMETERS
//   N_BITS     1024          solution width; power of two, >= 2
//   SEED       32'hACE1_2024 LFSR seed, reloaded on every accepted start; must be nonzero
//   MAX_ITERS  16*N_BITS     SEARCH-cycle cap before forced termination; >= 1
// PORTS
//   clk            in   1                    rising-edge clock, single clock domain
//   rst_n          in   1                    reset, asynchronous, active-low
//   start          in   1                    1-cycle pulse; begins a run when not busy
//   best_solution  out  N_BITS               current/best vector
//   best_fitness   out  $clog2(N_BITS)+2     number of 1s in best_solution
//   done           out  1                    high while result is valid; held until next start
// BEHAVIOUR
//   - Reset (async assert, clk-synchronous deassert by use): state=IDLE, best_solution=0,
//     best_fitness=0, done=0, LFSR=SEED, counters=0.
//   - LFSR: 32-bit Galois, taps 32'h8020_0003 (x^32+x^22+x^2+x+1), shift right; advances once
//     per cycle in INIT and SEARCH only; never reaches all-zero.
//   - FSM states: IDLE, INIT, SEARCH, DONE.
//   - IDLE/DONE + start=1: next edge -> INIT; best_solution=0, best_fitness=0, bit counter=0,
//     iteration counter=0, LFSR=SEED, done=0. start in INIT/SEARCH is ignored.
//   - INIT: one bit per cycle for N_BITS cycles: best_solution[cnt] <= lfsr[0];
//     best_fitness += lfsr[0]; cnt++. After bit N_BITS-1 is written -> SEARCH.
//   - SEARCH, per cycle, priority order:
//       1) best_fitness == N_BITS -> DONE (no flip this cycle)
//       2) iter == MAX_ITERS      -> DONE
//       3) idx = lfsr[$clog2(N_BITS)-1:0]; if best_solution[idx]==0 set it and
//          best_fitness += 1, else no change (flips that would lower fitness rejected); iter++.
//   - DONE: done=1; outputs frozen; stays until start (-> INIT) or reset.
//   - Latency: start to done >= N_BITS+2 cycles; deterministic for a given SEED/N_BITS.
//   - Invariant every cycle: best_fitness == popcount(best_solution); fitness monotonic
//     non-decreasing during SEARCH; never exceeds N_BITS.
//   - Reset mid-run: immediate return to reset values; no partial result retained.
//   - start coincident with reset deassertion edge is ignored (reset wins).
// TESTING
//   1) N_BITS=1024: reset 2 cycles, pulse start -> done rises; best_fitness==1024,
//      best_solution all ones; done stays high 10 cycles later, outputs unchanged.
//   2) Reset values: while rst_n=0 -> done=0, best_fitness=0, best_solution=0, even mid-run.
//   3) N_BITS=16, MAX_ITERS=4: start -> done after exactly 16+4+2 cycles (unless optimum
//      earlier); best_fitness == $countones(best_solution) <= 16.
//   4) start pulsed during INIT and SEARCH -> ignored; cycle count to done unchanged vs. run 1.
//   5) Two runs back-to-back with same SEED -> identical cycle count and identical results;
//      done drops one cycle after second start.
//   6) Assertion every cycle: best_fitness == $countones(best_solution), monotonic in SEARCH.

Source files
------------

// File: rtl/one_max_solver.sv
// OneMax hill-climbing accelerator: random initial vector, then accept-only-improving single-bit flips.
module one_max_solver #(
  parameter int unsigned N_BITS    = 1024,
  parameter logic [31:0] SEED      = 32'hACE1_2024,
  parameter int unsigned MAX_ITERS = 16 * N_BITS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic [N_BITS-1:0]            best_solution,
  output logic [$clog2(N_BITS)+1:0]    best_fitness,
  output logic                         done
);

  localparam int unsigned IDX_W  = $clog2(N_BITS);
  localparam int unsigned FIT_W  = IDX_W + 2;
  localparam int unsigned ITER_W = $clog2(MAX_ITERS + 1);
  localparam logic [31:0] TAPS   = 32'h8020_0003;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INIT   = 2'd1,
    S_SEARCH = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [N_BITS-1:0]   sol_q, sol_d;
  logic [FIT_W-1:0]    fit_q, fit_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic                done_q, done_d;

  logic [31:0]         lfsr_nxt_c;
  logic [IDX_W-1:0]    idx_c;
  logic                at_opt_c;
  logic                at_cap_c;
  logic                last_bit_c;

  // Shared decode: Galois LFSR step, flip index and termination conditions
  always_comb begin
    lfsr_nxt_c = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
    idx_c      = lfsr_q[IDX_W-1:0];
    at_opt_c   = (fit_q == FIT_W'(N_BITS));
    at_cap_c   = (iter_q == ITER_W'(MAX_ITERS));
    last_bit_c = (cnt_q == IDX_W'(N_BITS - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured from IDLE or DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_INIT;
      S_INIT:         if (last_bit_c) state_d = S_SEARCH;
      S_SEARCH:       if (at_opt_c || at_cap_c) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Datapath/output next values; optimum check takes priority over the iteration cap
  always_comb begin
    sol_d  = sol_q;
    fit_d  = fit_q;
    cnt_d  = cnt_q;
    iter_d = iter_q;
    lfsr_d = lfsr_q;
    done_d = (state_d == S_DONE);
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sol_d  = '0;
          fit_d  = '0;
          cnt_d  = '0;
          iter_d = '0;
          lfsr_d = SEED;
        end
      end
      S_INIT: begin
        sol_d[cnt_q] = lfsr_q[0];
        fit_d        = fit_q + FIT_W'(lfsr_q[0]);
        cnt_d        = cnt_q + IDX_W'(1);
        lfsr_d       = lfsr_nxt_c;
      end
      S_SEARCH: begin
        lfsr_d = lfsr_nxt_c;
        if (!at_opt_c && !at_cap_c) begin
          if (!sol_q[idx_c]) begin
            sol_d[idx_c] = 1'b1;
            fit_d        = fit_q + FIT_W'(1);
          end
          iter_d = iter_q + ITER_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sol_q  <= '0;
      fit_q  <= '0;
      cnt_q  <= '0;
      iter_q <= '0;
      lfsr_q <= SEED;
      done_q <= 1'b0;
    end else begin
      sol_q  <= sol_d;
      fit_q  <= fit_d;
      cnt_q  <= cnt_d;
      iter_q <= iter_d;
      lfsr_q <= lfsr_d;
      done_q <= done_d;
    end
  end

  assign best_solution = sol_q;
  assign best_fitness  = fit_q;
  assign done          = done_q;

endmodule

// File: tb/tb_one_max_solver.sv
// Scoreboard bench for one_max_solver: a 16-bit/4-iteration instance and a default 1024-bit instance.
module tb_one_max_solver;

  localparam logic [31:0] SEED = 32'hACE1_2024;
  localparam int NS = 16;
  localparam int MS = 4;
  localparam int NB = 1024;
  localparam int MB = 16 * 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_s = 1'b0;
  logic start_b = 1'b0;

  logic [NS-1:0] sol_s;
  logic [5:0]    fit_s;
  logic          done_s;
  logic [NB-1:0] sol_b;
  logic [11:0]   fit_b;
  logic          done_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic [NB-1:0] sol;
    int            fit;
    int            lat;
    int            start_cyc;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  one_max_solver #(.N_BITS(NS), .SEED(SEED), .MAX_ITERS(MS)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s),
    .best_solution(sol_s), .best_fitness(fit_s), .done(done_s)
  );

  one_max_solver dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .best_solution(sol_b), .best_fitness(fit_b), .done(done_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NB-1:0] sol_of(int d);
    return (d == 0) ? NB'(sol_s) : sol_b;
  endfunction

  function automatic int fit_of(int d);
    return (d == 0) ? int'(fit_s) : int'(fit_b);
  endfunction

  function automatic logic done_of(int d);
    return (d == 0) ? done_s : done_b;
  endfunction

  task automatic chk(string nm, logic [NB-1:0] act, logic [NB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: polynomial x^32+x^22+x^2+x+1 in right-shifting Galois form
  function automatic logic [31:0] lfsr_adv(logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
  endfunction

  // Reference run: fill from LFSR bit 0, then climb until optimum or cap; latency counts the start edge
  function automatic exp_t model(int n, int mx, int sc);
    exp_t e;
    logic [31:0] l;
    int iters;
    int search_cycles;
    int idx;
    l = SEED;
    e.sol = '0;
    e.fit = 0;
    iters = 0;
    search_cycles = 0;
    for (int i = 0; i < n; i++) begin
      e.sol[i] = l[0];
      e.fit += int'(l[0]);
      l = lfsr_adv(l);
    end
    while (1) begin
      search_cycles++;
      if (e.fit == n || iters == mx) break;
      idx = int'(l % 32'(n));
      if (!e.sol[idx]) begin
        e.sol[idx] = 1'b1;
        e.fit++;
      end
      iters++;
      l = lfsr_adv(l);
    end
    e.lat = 1 + n + search_cycles;
    e.start_cyc = sc;
    return e;
  endfunction

  // Monitor state per instance
  bit            pv[2];
  bit            pd[2];
  logic [NB-1:0] ps[2];
  int            pf[2];

  task automatic mon(int d);
    logic [NB-1:0] s;
    int f;
    logic dn;
    exp_t e;
    bit got;
    s = sol_of(d);
    f = fit_of(d);
    dn = done_of(d);
    if (!rst_n) begin
      pv[d] = 1'b0;
      return;
    end
    chk($sformatf("popcount%0d", d), NB'(f), NB'($countones(s)));
    if (pv[d] && !pd[d]) begin
      n_cmp++;
      if (f < pf[d]) begin
        n_err++;
        $display("FAIL monotonic%0d: got %0d after %0d", d, f, pf[d]);
      end
    end
    if (pv[d] && pd[d] && dn) begin
      chk($sformatf("frozen_sol%0d", d), s, ps[d]);
      chk($sformatf("frozen_fit%0d", d), NB'(f), NB'(pf[d]));
    end
    if (dn && !(pv[d] && pd[d])) begin
      got = 1'b0;
      if (d == 0 && exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        got = 1'b1;
      end else if (d == 1 && exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        got = 1'b1;
      end
      if (!got) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done%0d: got done with no run pending, want none", d);
      end else begin
        chk($sformatf("fitness%0d", d), NB'(f), NB'(e.fit));
        chk($sformatf("solution%0d", d), s, e.sol);
        chk($sformatf("latency%0d", d), NB'(cyc - e.start_cyc), NB'(e.lat));
      end
    end
    pv[d] = 1'b1;
    pd[d] = dn;
    ps[d] = s;
    pf[d] = f;
  endtask

  always @(negedge clk) mon(0);
  always @(negedge clk) mon(1);

  task automatic set_start(int d, logic v);
    if (d == 0) start_s = v;
    else start_b = v;
  endtask

  // Issue an accepted start (called just after a negedge) and queue its expected result
  task automatic issue_run(int d);
    exp_t e;
    e = model((d == 0) ? NS : NB, (d == 0) ? MS : MB, cyc);
    if (d == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
    set_start(d, 1'b1);
    @(negedge clk);
    set_start(d, 1'b0);
    chk($sformatf("done_drop%0d", d), NB'(done_of(d)), NB'(0));
  endtask

  // Wait for done with a cycle bound, optionally pulsing start while busy
  task automatic wait_done(int d, int bound, bit noise);
    int k;
    k = 0;
    while (!done_of(d) && k < bound) begin
      set_start(d, (noise && $urandom_range(3) == 0) ? 1'b1 : 1'b0);
      @(negedge clk);
      k++;
    end
    set_start(d, 1'b0);
    n_cmp++;
    if (!done_of(d)) begin
      n_err++;
      $display("FAIL timeout%0d: done low after %0d cycles, want high", d, bound);
    end
  endtask

  task automatic chk_reset();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_done%0d", d), NB'(done_of(d)), NB'(0));
      chk($sformatf("rst_fit%0d", d), NB'(fit_of(d)), NB'(0));
      chk($sformatf("rst_sol%0d", d), sol_of(d), NB'(0));
    end
  endtask

  initial begin
    logic [NB-1:0] ones;
    int k;
    ones = '1;

    // Start held during reset must not launch a run
    rst_n = 1'b0;
    start_s = 1'b1;
    start_b = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    start_s = 1'b0;
    start_b = 1'b0;
    repeat (NS + 8) @(negedge clk);
    chk("idle_done_s", NB'(done_s), NB'(0));
    chk("idle_fit_s", NB'(fit_s), NB'(0));
    chk("idle_fit_b", NB'(fit_b), NB'(0));

    // Full-size run reaches the optimum and holds it
    issue_run(1);
    wait_done(1, 20000, 1'b1);
    repeat (10) @(negedge clk);
    chk("held_done_b", NB'(done_b), NB'(1));
    chk("held_fit_b", NB'(fit_b), NB'(NB));
    chk("held_sol_b", sol_b, ones);

    // Small instance: back-to-back runs, ignored starts, random mid-run resets
    for (int r = 0; r < 40; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue_run(0);
      if ($urandom_range(3) == 0) begin
        k = $urandom_range(1, 15);
        repeat (k) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset();
        if (exp_q0.size() > 0) void'(exp_q0.pop_front());
        repeat (2) @(negedge clk);
        chk_reset();
        rst_n = 1'b1;
      end else begin
        wait_done(0, 100, 1'b1);
        repeat ($urandom_range(0, 5)) @(negedge clk);
        chk("held_done_s", NB'(done_s), NB'(1));
      end
    end

    repeat (3) @(negedge clk);
    chk("pending_s", NB'(exp_q0.size()), NB'(0));
    chk("pending_b", NB'(exp_q1.size()), NB'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
